imm_encoder: RTL

Instruction-word encoder for the RISC-V single-cycle datapath: the inverse of the immediate sign-extension decoder. It accepts decoded fields (opcode, registers, funct, 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit RV32I instruction word in the correct R/I/S/B/J/U bit layout. Immediates that do not fit the format are range- and alignment-checked. The result leaves through a two-entry skid buffer, so the block can feed the instruction-memory loader and the self-test program generator without combinational ready paths.

---
 rtl/rv32_pkg.sv | 44 ++++
 rtl/imm_decode_check.sv | 26 ++
 rtl/imm_encoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction formats, NOP word
// and the stored skid-buffer entry type.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_word_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:             f = FMT_R;
      OP_LOAD, OP_IMM:  f = FMT_I;
      OP_STORE:         f = FMT_S;
      OP_BRANCH:        f = FMT_B;
      OP_JAL:           f = FMT_J;
      OP_LUI:           f = FMT_U;
      default:          f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_decode_check.sv
// Combinational immediate decoder mirroring the datapath's bit selections.
// Present only when IMM_ENC_ROUNDTRIP_CHECK_EN is defined.
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
module imm_decode_check
  import rv32_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (opcode_fmt(i_instr[6:0]))
      FMT_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      FMT_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      FMT_U:   o_imm = {i_instr[31:12], 12'b0};
      default: o_imm = '0;
    endcase
  end

endmodule
`endif

// File: rtl/imm_encoder.sv
// RV32I instruction encoder with range checks feeding a two-entry skid buffer.
// IMM_ENC_ROUNDTRIP_CHECK_EN adds a decode-back checker driving chk_fail.
module imm_encoder
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count,
  output logic        chk_fail
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e      r_state, w_state_d;
  enc_word_t r_main, r_skid, w_new;
  fmt_e      w_fmt;
  logic [31:0] w_enc;
  logic      w_bad, w_acc, w_drain;
  logic      w_load_main, w_load_skid, w_main_from_skid;
  logic      r_out_valid, r_in_ready;
  logic [7:0] r_err_count;

  always_comb begin
    w_fmt = opcode_fmt(in_opcode);
    w_enc = NOP;
    w_bad = 1'b0;
    case (w_fmt)
      FMT_R: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        w_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        w_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        w_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
        w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                 in_imm[11], in_opcode};
      end
      FMT_J: begin
        w_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
        w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      FMT_U: begin
        w_bad = |in_imm[11:0];
        w_enc = {in_imm[31:12], in_rd, in_opcode};
      end
      default: w_bad = 1'b1;
    endcase
    w_new.instr = w_bad ? NOP : w_enc;
    w_new.err   = w_bad;
  end

  // Occupancy FSM: the skid entry is valid exactly in StFull.
  always_comb begin
    w_acc            = in_valid && r_in_ready;
    w_drain          = r_out_valid && out_ready;
    w_state_d        = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_acc) begin
          w_load_main = 1'b1;
          w_state_d   = StOne;
        end
      end
      StOne: begin
        if (w_acc && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_load_skid = 1'b1;
          w_state_d   = StFull;
        end else if (w_drain) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_drain) begin
          w_main_from_skid = 1'b1;
          w_state_d        = StOne;
        end
      end
      default: w_state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= '0;
      r_skid      <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_out_valid <= (w_state_d != StEmpty);
      r_in_ready  <= (w_state_d != StFull);
      if (w_load_main) begin
        r_main <= w_new;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_new;
      end
      if (w_acc && w_new.err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_main.instr;
  assign out_err   = r_main.err;
  assign err_count = r_err_count;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  logic [31:0] r_main_imm, r_skid_imm, w_dec_imm;
  logic        r_main_chk, r_skid_chk, r_main_new, w_chk_new;

  assign w_chk_new = !w_new.err && (w_fmt != FMT_R);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_skid_imm <= '0;
      r_main_chk <= 1'b0;
      r_skid_chk <= 1'b0;
      r_main_new <= 1'b0;
    end else begin
      r_main_new <= w_load_main || w_main_from_skid;
      if (w_load_main) begin
        r_main_imm <= in_imm;
        r_main_chk <= w_chk_new;
      end else if (w_main_from_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_chk <= r_skid_chk;
      end
      if (w_load_skid) begin
        r_skid_imm <= in_imm;
        r_skid_chk <= w_chk_new;
      end
    end
  end

  imm_decode_check u_imm_decode_check (
    .i_instr (r_main.instr),
    .o_imm   (w_dec_imm)
  );

  assign chk_fail = r_main_new && r_main_chk && (w_dec_imm != r_main_imm);
`else
  assign chk_fail = 1'b0;
`endif

endmodule
